// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 geometry (pixels / lines)
//   - geometry_total(): total line or frame length from its four segments
//   - POL_LOW / POL_HIGH sync polarity constants
//   - vga_dec_t: one decoded pixel {hs, vs, bright, ls, fs} as carried
//     through the output pipeline
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bright;
    logic ls;
    logic fs;
  } vga_dec_t;

  function automatic int geometry_total(input int active, input int fp,
                                        input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// -----------------------------------------------------------------------------
// clk_en_div
// Pixel clock-enable divider. Produces a one-clock enable pulse every DIV
// system clocks; no derived clock is generated.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   i_en   : run enable; low freezes the count and suppresses o_ce
//   o_ce   : high in the clock where the count equals DIV-1
// -----------------------------------------------------------------------------
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_ce
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  // With DIV=1 the count never leaves 0, so the enable simply follows i_en.
  assign w_tc = (r_cnt == TC);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  // Gated by reset so the enable is low throughout reset even when DIV=1.
  assign o_ce = i_en & ~i_rst & w_tc;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Single-clock VGA raster timing generator with configurable geometry, sync
// polarity and output pipeline depth.
//   clk, rst, en   : system clock, async active-high reset, run enable
//   pix_ce         : one-clock pixel enable
//   hcount, vcount : current pixel column / line
//   hsync, vsync   : syncs at HS_POL / VS_POL level when active
//   bright         : active-video flag
//   line_start     : one-clock pulse at line start
//   frame_start    : one-clock pulse at frame start
// hsync/vsync/bright and the strobes lag hcount/vcount by 1+PIPE pixels.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = POL_LOW,
  parameter bit VS_POL   = POL_LOW,
  parameter int PIPE     = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          bright,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = geometry_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = geometry_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);

  localparam vga_dec_t IDLE = '{hs: ~HS_POL, vs: ~VS_POL,
                                bright: 1'b0, ls: 1'b0, fs: 1'b0};

  if ((1 << CW) < max2(H_TOTAL, V_TOTAL)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (PIPE < 0 || PIPE > 3) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be 0..3");
  end

  logic          w_pix_ce;
  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  vga_dec_t      w_dec;
  vga_dec_t      r_pipe [PIPE+1];

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .o_ce  (w_pix_ce)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_pix_ce) begin
      if (r_hcount == H_LAST) begin
        r_hcount <= '0;
        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
    end
  end

  always_comb begin
    w_dec        = IDLE;
    w_dec.hs     = (r_hcount >= HS_FIRST && r_hcount <= HS_LAST) ? HS_POL : ~HS_POL;
    w_dec.vs     = (r_vcount >= VS_FIRST && r_vcount <= VS_LAST) ? VS_POL : ~VS_POL;
    w_dec.bright = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    w_dec.ls     = (r_hcount == '0);
    w_dec.fs     = (r_hcount == '0) && (r_vcount == '0);
  end

  // Stage 0 registers the decode; stages 1..PIPE add pixel-rate delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PIPE; i++) begin
        r_pipe[i] <= IDLE;
      end
    end else if (w_pix_ce) begin
      r_pipe[0] <= w_dec;
      for (int i = 1; i <= PIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign pix_ce      = w_pix_ce;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_pipe[PIPE].hs;
  assign vsync       = r_pipe[PIPE].vs;
  assign bright      = r_pipe[PIPE].bright;
  // The strobe registers stay high for a whole pixel; gating with the
  // enable narrows them to a single clock.
  assign line_start  = r_pipe[PIPE].ls & w_pix_ce;
  assign frame_start = r_pipe[PIPE].fs & w_pix_ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen using three instances:
//   u0 : default 640x480 geometry, CLK_DIV=4, PIPE=0
//   u1 : default geometry, CLK_DIV=1, PIPE=2, HS_POL=1
//   u2 : small geometry H 8/1/2/1, V 4/1/1/1, CW=4, CLK_DIV=3, PIPE=1
// Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- u0 ----------------
  logic       rst0 = 1'b1, en0 = 1'b1;
  logic       ce0, hs0, vs0, br0, ls0, fs0;
  logic [9:0] hc0, vc0;

  vga_timing_gen u0 (
    .clk(clk), .rst(rst0), .en(en0), .pix_ce(ce0), .hcount(hc0), .vcount(vc0),
    .hsync(hs0), .vsync(vs0), .bright(br0), .line_start(ls0), .frame_start(fs0)
  );

  // ---------------- u1 ----------------
  logic       rst1 = 1'b1, en1 = 1'b1;
  logic       ce1, hs1, vs1, br1, ls1, fs1;
  logic [9:0] hc1, vc1;

  vga_timing_gen #(.CLK_DIV(1), .PIPE(2), .HS_POL(1'b1)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .pix_ce(ce1), .hcount(hc1), .vcount(vc1),
    .hsync(hs1), .vsync(vs1), .bright(br1), .line_start(ls1), .frame_start(fs1)
  );

  // ---------------- u2 ----------------
  logic       rst2 = 1'b1, en2 = 1'b1;
  logic       ce2, hs2, vs2, br2, ls2, fs2;
  logic [3:0] hc2, vc2;

  vga_timing_gen #(
    .CLK_DIV(3), .PIPE(1), .CW(4),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u2 (
    .clk(clk), .rst(rst2), .en(en2), .pix_ce(ce2), .hcount(hc2), .vcount(vc2),
    .hsync(hs2), .vsync(vs2), .bright(br2), .line_start(ls2), .frame_start(fs2)
  );

  // Expected u2 outputs for pixel index k since reset and divider phase md.
  // H_TOTAL=12 (hsync 9..10), V_TOTAL=7 (vsync line 5), lag 2 pixels.
  function automatic logic [13:0] exp_u2(input int k, input int md);
    int   j, h, v;
    logic ce, hs, vs, br, ls, fs;
    ce = (md == 2);
    hs = 1'b1; vs = 1'b1; br = 1'b0; ls = 1'b0; fs = 1'b0;
    j = k - 2;
    if (j >= 0) begin
      h  = j % 12;
      v  = (j / 12) % 7;
      hs = !(h >= 9 && h <= 10);
      vs = (v != 5);
      br = (h < 8) && (v < 4);
      ls = ce && (h == 0);
      fs = ce && (h == 0) && (v == 0);
    end
    return {ce, 4'(k % 12), 4'((k / 12) % 7), hs, vs, br, ls, fs};
  endfunction

  // Run u2 from just after reset release for n_clk clocks against the model.
  task automatic run_u2(input string tag, input int n_clk, output int n_fs);
    int k, md;
    k = 0; md = 0; n_fs = 0;
    for (int c = 0; c < n_clk; c++) begin
      chk(tag, {ce2, hc2, vc2, hs2, vs2, br2, ls2, fs2}, exp_u2(k, md));
      if (fs2) n_fs++;
      if (md == 2) begin k++; md = 0; end
      else md++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ce, n_hs, n_br, n_ls, n_fs, ls_h, hs_first, wraps, prev_h, n_off;

    // ===== u0: reset values, first pix_ce, one full line =====
    repeat (2) tick();
    chk("u0 rst hcount", hc0, 0);
    chk("u0 rst vcount", vc0, 0);
    chk("u0 rst pix_ce", ce0, 0);
    chk("u0 rst hsync", hs0, 1);
    chk("u0 rst vsync", vs0, 1);
    chk("u0 rst bright", br0, 0);
    chk("u0 rst ls", ls0, 0);
    chk("u0 rst fs", fs0, 0);
    rst0 = 1'b0;
    #1;
    chk("u0 ce clk0", ce0, 0);
    tick(); chk("u0 ce clk1", ce0, 0);
    tick(); chk("u0 ce clk2", ce0, 0);
    tick(); chk("u0 ce clk3", ce0, 1);
    tick(); chk("u0 first hcount", hc0, 1);

    n_ce = 0; n_hs = 0; n_br = 0; n_ls = 0; n_fs = 0;
    ls_h = -1; hs_first = -1; wraps = 0;
    for (int c = 0; c < 4000 && n_ce < 800; c++) begin
      if (ce0) begin
        n_ce++;
        if (!hs0) begin
          n_hs++;
          if (hs_first < 0) hs_first = int'(hc0);
        end
        if (br0) n_br++;
      end
      if (ls0) begin n_ls++; ls_h = int'(hc0); end
      if (fs0) n_fs++;
      prev_h = int'(hc0);
      tick();
      if (prev_h == 799 && hc0 == 10'd0 && vc0 == 10'd1) wraps++;
    end
    chk("u0 line pix_ce", n_ce, 800);
    chk("u0 hsync low", n_hs, 96);
    chk("u0 hsync first", hs_first, 657);
    chk("u0 bright", n_br, 640);
    chk("u0 ls clocks", n_ls, 1);
    chk("u0 ls hcount", ls_h, 1);
    chk("u0 fs clocks", n_fs, 1);
    chk("u0 hwrap", wraps, 1);

    // ===== u1: CLK_DIV=1, en pause, PIPE=2 with active-high hsync =====
    chk("u1 rst pix_ce", ce1, 0);
    chk("u1 rst hsync", hs1, 0);
    chk("u1 rst vsync", vs1, 1);
    rst1 = 1'b0;
    #1;
    chk("u1 ce release", ce1, 1);
    n_off = 0;
    for (int c = 0; c < 400 && hc1 != 10'd100; c++) begin
      if (!ce1) n_off++;
      tick();
    end
    chk("u1 reach 100", hc1, 100);
    chk("u1 ce steady", n_off, 0);
    en1 = 1'b0;
    #1;
    chk("u1 ce paused", ce1, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("u1 hold hcount", hc1, 100);
    end
    chk("u1 hold bright", br1, 1);
    chk("u1 hold hsync", hs1, 0);
    en1 = 1'b1;
    #1;
    chk("u1 ce resume", ce1, 1);
    tick();
    chk("u1 resume hcount", hc1, 101);

    for (int c = 0; c < 2000 && hs1 !== 1'b1; c++) tick();
    chk("u1 hsync first", hc1, 659);
    n_hs = 0; n_ls = 0; n_fs = 0; ls_h = -1;
    for (int c = 0; c < 800; c++) begin
      if (ce1 && hs1) n_hs++;
      if (ls1) begin n_ls++; ls_h = int'(hc1); end
      if (fs1) n_fs++;
      tick();
    end
    chk("u1 hsync high", n_hs, 96);
    chk("u1 ls clocks", n_ls, 1);
    chk("u1 ls hcount", ls_h, 3);
    chk("u1 fs clocks", n_fs, 0);

    // ===== u2: small geometry pixel-by-pixel, mid-frame reset =====
    chk("u2 rst vec", {ce2, hc2, vc2, hs2, vs2, br2, ls2, fs2},
        {1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    rst2 = 1'b0;
    #1;
    run_u2("u2 px", 2 * 84 * 3, n_fs);
    chk("u2 fs count", n_fs, 2);

    for (int c = 0; c < 400 && !(hc2 == 4'd5 && vc2 == 4'd2); c++) tick();
    chk("u2 pre-rst bright", br2, 1);
    rst2 = 1'b1;
    #1;
    chk("u2 midrst hcount", hc2, 0);
    chk("u2 midrst vcount", vc2, 0);
    chk("u2 midrst hsync", hs2, 1);
    chk("u2 midrst vsync", vs2, 1);
    chk("u2 midrst bright", br2, 0);
    chk("u2 midrst pix_ce", ce2, 0);
    tick();
    tick();
    rst2 = 1'b0;
    #1;
    run_u2("u2 restart", 84 * 3 + 6, n_fs);
    chk("u2 restart fs", n_fs, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
